fifo_read_serializer: RTL and testbench

FIFO_READ_SERIALIZER -- requirements
Module: fifo_read_serializer

---
 rtl/fifo_read_serializer.sv | 110 +++++++++++
 tb/tb_fifo_read_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_serializer.sv
// Reads PAR_READ words from a FIFO in one parallel read and streams them out one per handshake.
// Optional macro FIFO_READ_SERIALIZER_COUNT_EN adds a 16-bit accepted-word counter output.
module fifo_read_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_READ   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data [PAR_READ-1:0],
    input  logic                  fifo_empty,
    input  logic                  fifo_valid,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
`ifdef FIFO_READ_SERIALIZER_COUNT_EN
    ,
    output logic [15:0]           word_count
`endif
);

    localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [DATA_WIDTH-1:0] cap_q [PAR_READ-1:0];
    logic [DATA_WIDTH-1:0] cap_d [PAR_READ-1:0];
    logic                  xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            cap_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cap_q   <= cap_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        index_d          = index_q;
        cap_d            = cap_q;
        fifo_read_enable = 1'b0;
        xfer             = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = REQ;
            end
            REQ: begin
                fifo_read_enable = 1'b1;
                state_d          = WAIT;
            end
            WAIT: begin
                if (fifo_valid) begin
                    cap_d   = fifo_data;
                    index_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (index_q == LAST_IDX) begin
                        index_d = '0;
                        state_d = IDLE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs derive only from registered state, so they change on the capture edge.
    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && (index_q == LAST_IDX);
        out_data  = (state_q == SEND) ? cap_q[index_q] : '0;
    end

`ifdef FIFO_READ_SERIALIZER_COUNT_EN
    logic [15:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    always_comb begin
        count_d = count_q;
        if (xfer) count_d = count_q + 16'd1;
    end

    assign word_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Scoreboard bench for fifo_read_serializer: expected words queued at FIFO delivery, popped on transfer.
module tb_fifo_read_serializer;

    localparam int DW = 8;
    localparam int PR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_data [PR-1:0];
    logic          fifo_empty = 1'b1;
    logic          fifo_valid = 1'b0;
    logic          fifo_read_enable;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
`ifdef FIFO_READ_SERIALIZER_COUNT_EN
    logic [15:0]   word_count;
`endif

    logic [DW-1:0] exp_q [$];
    int n_vec  = 0;
    int n_miss = 0;
    int rd_pulses = 0;

    always #5 clk = ~clk;

    fifo_read_serializer #(.DATA_WIDTH(DW), .PAR_READ(PR)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_data        (fifo_data),
        .fifo_empty       (fifo_empty),
        .fifo_valid       (fifo_valid),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last)
`ifdef FIFO_READ_SERIALIZER_COUNT_EN
        ,
        .word_count       (word_count)
`endif
    );

    always @(negedge clk) if (fifo_read_enable === 1'b1) rd_pulses++;

    // Request a group and answer the read one cycle later; returns at the negedge showing word 0.
    task automatic fetch(input logic [DW-1:0] w0, w1, w2, w3, output bit ok);
        ok = 1'b0;
        fifo_empty = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (fifo_read_enable === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            @(negedge clk);
            fifo_valid   = 1'b1;
            fifo_data[0] = w0; fifo_data[1] = w1; fifo_data[2] = w2; fifo_data[3] = w3;
            exp_q.push_back(w0); exp_q.push_back(w1); exp_q.push_back(w2); exp_q.push_back(w3);
            @(negedge clk);
            fifo_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1; fifo_empty = 1'b1; out_ready = 1'b0; fifo_valid = 1'b0;
        for (int i = 0; i < PR; i++) fifo_data[i] = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 || fifo_read_enable !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_outputs got v=%b l=%b d=%h re=%b exp all 0", out_valid, out_last, out_data, fifo_read_enable);
        end
        p0 = rd_pulses;
        repeat (20) @(negedge clk);
        n_vec++;
        if (rd_pulses - p0 !== 0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL idle_no_read got pulses=%0d v=%b exp 0 0", rd_pulses - p0, out_valid);
        end
    endtask

    task automatic test_stream();
        bit ok;
        int p0;
        p0 = rd_pulses;
        out_ready = 1'b1;
        fetch(8'hAA, 8'hFF, 8'h00, 8'h55, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL stream_read got no read_enable exp pulse"); return; end
        for (int k = 0; k < PR; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (k == PR - 1)) begin
                n_miss++;
                $display("FAIL stream_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", k, out_valid, out_data, out_last, exp_q[0], k == PR - 1);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        fifo_empty = 1'b1;
        n_vec++;
        if (out_valid !== 1'b0 || rd_pulses - p0 !== 1) begin
            n_miss++;
            $display("FAIL stream_end got v=%b pulses=%0d exp v=0 pulses=1", out_valid, rd_pulses - p0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int cyc;
        cyc = 0;
        out_ready = 1'b1;
        fetch(8'hAA, 8'hFF, 8'h00, 8'h55, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL bp_read got no read_enable exp pulse"); return; end
        while (exp_q.size() > 0 && cyc < 12) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (exp_q.size() == 1)) begin
                n_miss++;
                $display("FAIL bp_cycle%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", cyc, out_valid, out_data, out_last, exp_q[0], exp_q.size() == 1);
            end
            if (out_ready) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        fifo_empty = 1'b1;
        out_ready = 1'b1;
        n_vec++;
        if (cyc !== 7 || out_valid !== 1'b0 || exp_q.size() !== 0) begin
            n_miss++;
            $display("FAIL bp_end got cycles=%0d v=%b left=%0d exp 7 0 0", cyc, out_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        out_ready = 1'b1;
        fetch(8'h11, 8'h22, 8'h33, 8'h44, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL rstmid_read got no read_enable exp pulse"); return; end
        for (int k = 0; k < 2; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_miss++;
                $display("FAIL rstmid_word%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_vec++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00) begin
            n_miss++;
            $display("FAIL rstmid_flush got v=%b l=%b d=%h exp 0 0 00", out_valid, out_last, out_data);
        end
        fetch(8'h66, 8'h77, 8'h88, 8'h99, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL rstmid_reread got no read_enable exp pulse"); return; end
        for (int k = 0; k < PR; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (k == PR - 1)) begin
                n_miss++;
                $display("FAIL rstmid_new%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", k, out_valid, out_data, out_last, exp_q[0], k == PR - 1);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        fifo_empty = 1'b1;
    endtask

    task automatic test_spurious_valid();
        bit ok;
        fifo_empty = 1'b1;
        fifo_valid = 1'b1;
        for (int i = 0; i < PR; i++) fifo_data[i] = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0 || fifo_read_enable !== 1'b0) begin
                n_miss++;
                $display("FAIL spur_idle got v=%b re=%b exp 0 0", out_valid, fifo_read_enable);
            end
        end
        fifo_valid = 1'b0;
        out_ready = 1'b1;
        fetch(8'hA1, 8'hB2, 8'hC3, 8'hD4, ok);
        n_vec++;
        if (!ok) begin n_miss++; $display("FAIL spur_read got no read_enable exp pulse"); return; end
        for (int k = 0; k < PR; k++) begin
            fifo_valid = 1'b1;
            for (int i = 0; i < PR; i++) fifo_data[i] = 8'hE0 + 8'(k);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== (k == PR - 1)) begin
                n_miss++;
                $display("FAIL spur_send%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", k, out_valid, out_data, out_last, exp_q[0], k == PR - 1);
            end
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        fifo_empty = 1'b1;
        @(negedge clk);
        fifo_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_miss++;
            $display("FAIL spur_after got v=%b d=%h exp 0 00", out_valid, out_data);
        end
    endtask

`ifdef FIFO_READ_SERIALIZER_COUNT_EN
    task automatic test_count();
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (word_count !== 16'd0) begin
            n_miss++;
            $display("FAIL count_reset got %0d exp 0", word_count);
        end
        out_ready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            fetch(8'h01, 8'h02, 8'h03, 8'h04, ok);
            n_vec++;
            if (!ok) begin n_miss++; $display("FAIL count_read%0d got no read_enable exp pulse", g); return; end
            repeat (PR) begin
                void'(exp_q.pop_front());
                @(negedge clk);
            end
            fifo_empty = 1'b1;
        end
        n_vec++;
        if (word_count !== 16'd8) begin
            n_miss++;
            $display("FAIL count_two_groups got %0d exp 8", word_count);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_spurious_valid();
`ifdef FIFO_READ_SERIALIZER_COUNT_EN
        test_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
